// File: rtl/step_pkg.sv
// Shared types and constants for the step/free-run clock-enable generator.
package step_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    QUAL   = 2'd1,
    COMMIT = 2'd2
  } db_state_t;

  localparam int          CNT_W_DEFAULT = 25;
  localparam logic [24:0] DEBOUNCE_HW   = 25'd1000000;
  localparam logic [24:0] DEBOUNCE_SIM  = 25'd2;

endpackage

// File: rtl/step_enable_gen_sync_2ff.sv
// Two-flop synchronizer with asynchronous active-low reset (module sync_2ff).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/step_enable_gen.sv
// Debounced single-step / free-run clock-enable generator for the MIPS core on sys_clk.
// Optional `define STEP_COUNT_EN adds a 16-bit wrapping count of issued enables.
module step_enable_gen
  import step_pkg::*;
#(
  parameter int               CNT_W           = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = CNT_W'(DEBOUNCE_HW),
  parameter logic [CNT_W-1:0] RUN_DIV         = CNT_W'(2)
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        step_in,
  input  logic        run_mode,
  input  logic        hold,
  output logic        cpu_en,
  output logic        step_level,
  output logic        busy
`ifdef STEP_COUNT_EN
  ,
  output logic [15:0] step_count
`endif
);

  // A zero setting behaves as one; *_LAST is the terminal count value.
  localparam logic [CNT_W-1:0] DB_LAST  =
    (DEBOUNCE_CYCLES == '0) ? '0 : DEBOUNCE_CYCLES - CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_LAST =
    (RUN_DIV == '0) ? '0 : RUN_DIV - CNT_W'(1);

  logic w_raw_step;
  logic w_run_s;

  sync_2ff u_sync_step (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .d     (step_in),
    .q     (w_raw_step)
  );

  sync_2ff u_sync_run (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .d     (run_mode),
    .q     (w_run_s)
  );

  db_state_t        r_state;
  logic [CNT_W-1:0] r_db_cnt;
  logic             r_step_level;
  logic             r_busy;
  logic [CNT_W-1:0] w_db_cnt_inc;
  logic             w_commit_rise;

  assign w_db_cnt_inc  = r_db_cnt + CNT_W'(1);
  assign w_commit_rise = (r_state == COMMIT) && w_raw_step && !r_step_level;

  // Debounce: the detecting cycle counts as the first stable cycle.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_db_cnt     <= '0;
      r_step_level <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_raw_step != r_step_level) begin
            r_busy   <= 1'b1;
            r_db_cnt <= '0;
            r_state  <= (DB_LAST == '0) ? COMMIT : QUAL;
          end
        end
        QUAL: begin
          if (w_raw_step == r_step_level) begin
            r_busy   <= 1'b0;
            r_db_cnt <= '0;
            r_state  <= IDLE;
          end else begin
            r_db_cnt <= w_db_cnt_inc;
            if (w_db_cnt_inc == DB_LAST) begin
              r_state <= COMMIT;
            end
          end
        end
        COMMIT: begin
          r_step_level <= w_raw_step;
          r_busy       <= 1'b0;
          r_db_cnt     <= '0;
          r_state      <= IDLE;
        end
        default: begin
          r_busy   <= 1'b0;
          r_db_cnt <= '0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  logic             r_run_prev;
  logic             r_pending;
  logic             r_cpu_en;
  logic [CNT_W-1:0] r_div_cnt;
  logic             w_mode_edge;
  logic             w_step_fire;

  assign w_mode_edge = w_run_s ^ r_run_prev;
  // Blocking on r_cpu_en keeps single-step strobes at least one cycle apart.
  assign w_step_fire = r_pending && !hold && !r_cpu_en;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_prev <= 1'b0;
      r_pending  <= 1'b0;
      r_cpu_en   <= 1'b0;
      r_div_cnt  <= '0;
    end else begin
      r_run_prev <= w_run_s;
      if (w_mode_edge) begin
        r_pending <= 1'b0;
        r_cpu_en  <= 1'b0;
        r_div_cnt <= '0;
      end else if (w_run_s) begin
        r_pending <= 1'b0;
        if (hold) begin
          r_cpu_en <= 1'b0;
        end else if (r_div_cnt == DIV_LAST) begin
          r_cpu_en  <= 1'b1;
          r_div_cnt <= '0;
        end else begin
          r_cpu_en  <= 1'b0;
          r_div_cnt <= r_div_cnt + CNT_W'(1);
        end
      end else begin
        r_div_cnt <= '0;
        r_cpu_en  <= w_step_fire;
        r_pending <= w_commit_rise | (r_pending & ~w_step_fire);
      end
    end
  end

`ifdef STEP_COUNT_EN
  logic [15:0] r_step_count;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_count <= '0;
    end else if (r_cpu_en) begin
      r_step_count <= r_step_count + 16'd1;
    end
  end

  assign step_count = r_step_count;
`endif

  assign cpu_en     = r_cpu_en;
  assign step_level = r_step_level;
  assign busy       = r_busy;

endmodule

// File: tb/tb_step_enable_gen.sv
// Self-checking bench for step_enable_gen with a strobe-cycle scoreboard.
module tb_step_enable_gen;

  localparam int          W  = 32;
  localparam logic [24:0] DB = 25'd2;
  localparam logic [24:0] RD = 25'd3;

  logic sys_clk = 1'b0;
  logic rst_n;
  logic step_in;
  logic run_mode;
  logic hold;
  logic cpu_en;
  logic step_level;
  logic busy;
`ifdef STEP_COUNT_EN
  logic [15:0] step_count;
`endif

  step_enable_gen #(
    .CNT_W           (25),
    .DEBOUNCE_CYCLES (DB),
    .RUN_DIV         (RD)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .step_in    (step_in),
    .run_mode   (run_mode),
    .hold       (hold),
    .cpu_en     (cpu_en),
    .step_level (step_level),
    .busy       (busy)
`ifdef STEP_COUNT_EN
    ,
    .step_count (step_count)
`endif
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  int unsigned cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;
  int m_div;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Each cpu_en pulse must match the oldest expected strobe cycle.
  always @(negedge sys_clk) begin
    if (exp_q.size() > 0 && exp_q[0] < cyc) begin
      check_eq("missed_strobe", W'(cyc), exp_q.pop_front());
    end
    if (rst_n && cpu_en) begin
      n_pulses++;
      if (exp_q.size() == 0) check_eq("unexpected_strobe", W'(cpu_en), 0);
      else                   check_eq("strobe_cycle", W'(cyc), exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic fr_cycle(input logic h);
    logic [W-1:0] e;
    hold = h;
    e = W'(cyc) + 1;
    if (!h) begin
      if (m_div == int'(RD) - 1) begin
        exp_q.push_back(e);
        m_div = 0;
      end else begin
        m_div++;
      end
    end
    tick(1);
  endtask

  int n0;
  int p0;
  int p_rst;

  initial begin
    rst_n    = 1'b0;
    step_in  = 1'b0;
    run_mode = 1'b0;
    hold     = 1'b0;
    tick(3);
    check_eq("rst_cpu_en", W'(cpu_en), 0);
    check_eq("rst_step_level", W'(step_level), 0);
    check_eq("rst_busy", W'(busy), 0);
    rst_n = 1'b1;
    tick(2);

    // single press: strobe 6 edges after the driving edge
    n0 = int'(cyc);
    step_in = 1'b1;
    exp_q.push_back(W'(n0 + 6));
    tick(3);
    check_eq("t1_busy_a", W'(busy), 1);
    tick(1);
    check_eq("t1_busy_b", W'(busy), 1);
    tick(1);
    check_eq("t1_busy_done", W'(busy), 0);
    check_eq("t1_level", W'(step_level), 1);
    tick(5);
    check_eq("t1_drain", W'(exp_q.size()), 0);
    step_in = 1'b0;
    tick(10);
    check_eq("t1_release_level", W'(step_level), 0);

    // one-cycle glitch is rejected
    step_in = 1'b1;
    tick(1);
    step_in = 1'b0;
    tick(2);
    check_eq("t2_busy_qual", W'(busy), 1);
    tick(1);
    check_eq("t2_busy_abort", W'(busy), 0);
    tick(8);
    check_eq("t2_level", W'(step_level), 0);

    // two presses under hold collapse into one strobe
    hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step_in = 1'b1;
      tick(8);
      check_eq("t3_level_hi", W'(step_level), 1);
      step_in = 1'b0;
      tick(8);
    end
    check_eq("t3_level_lo", W'(step_level), 0);
    exp_q.push_back(W'(cyc) + 1);
    hold = 1'b0;
    tick(8);
    check_eq("t3_drain", W'(exp_q.size()), 0);

    // free-run at RUN_DIV=3, then hold freezes the phase
    run_mode = 1'b1;
    tick(3);
    m_div = 0;
    p0 = n_pulses;
    for (int k = 0; k < 30; k++) fr_cycle(1'b0);
    for (int k = 0; k < 5; k++) fr_cycle(1'b1);
    check_eq("t4_pulses_30", W'(n_pulses - p0), 10);
    for (int k = 0; k < 9; k++) fr_cycle(1'b0);
    run_mode = 1'b0;
    fr_cycle(1'b0);
    fr_cycle(1'b0);
    tick(8);
    check_eq("t4_pulses_total", W'(n_pulses - p0), 13);
    check_eq("t4_drain", W'(exp_q.size()), 0);

    // reset during qualification, then requalify held-high input
    step_in = 1'b1;
    tick(3);
    check_eq("t5_busy_qual", W'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_cpu_en", W'(cpu_en), 0);
    check_eq("t5_rst_level", W'(step_level), 0);
    check_eq("t5_rst_busy", W'(busy), 0);
    tick(2);
    rst_n = 1'b1;
    p_rst = n_pulses;
    exp_q.push_back(W'(cyc) + 6);
    tick(12);
    check_eq("t5_level", W'(step_level), 1);
    check_eq("t5_one_pulse", W'(n_pulses - p_rst), 1);
`ifdef STEP_COUNT_EN
    check_eq("step_count", W'(step_count), W'(n_pulses - p_rst));
`endif

    check_eq("queue_empty", W'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
